t03_load_store_unit: RTL and testbench

//   Sits between the CPU execute stage and the t03 data memory. Turns one load/store

---
 rtl/t03_load_store_unit.sv | 206 ++++++++++++++++++++
 tb/tb_t03_load_store_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/t03_load_store_unit.sv
// Load/store unit between the execute stage and t03 data memory: word-aligned access, lane
// extract/sign-extend on loads, read-modify-write for SB/SH. Optional T03_LSU_MISALIGN_TRAP_EN.
module t03_load_store_unit #(
  parameter int unsigned RD_WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  output logic        ls_busy,
  output logic        ls_misaligned,
  output logic [31:0] data_address,
  output logic        dm_read_en,
  output logic        dm_write_en,
  output logic [31:0] data_to_write,
  input  logic [31:0] data_read
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_FAULT,
    S_DONE
  } state_t;

  localparam int unsigned CW = (RD_WAIT_CYCLES > 1) ? $clog2(RD_WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_WAIT_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          we_q, we_n;
  logic [2:0]    f3_q, f3_n;
  logic [1:0]    lo_q, lo_n;
  logic [31:0]   wdata_q, wdata_n;
  logic          mis_q, mis_n;

  logic [31:0]   ls_rdata_n, data_address_n, data_to_write_n;
  logic          ls_done_n, ls_busy_n, ls_misaligned_n, dm_read_en_n, dm_write_en_n;

  // Request decode, only meaningful in IDLE
  logic       req_legal, req_trap, req_mis;
  logic [1:0] req_lo;

  always_comb begin
    req_legal = 1'b0;
    if (ls_we) begin
      req_legal = (ls_funct3 == 3'b000) || (ls_funct3 == 3'b001) || (ls_funct3 == 3'b010);
    end else begin
      req_legal = (ls_funct3 != 3'b011) && (ls_funct3 != 3'b110) && (ls_funct3 != 3'b111);
    end
    req_mis = 1'b0;
    req_lo  = ls_addr[1:0];
    case (ls_funct3[1:0])
      2'b01:   req_lo = {ls_addr[1], 1'b0};
      2'b10:   req_lo = 2'b00;
      default: req_lo = ls_addr[1:0];
    endcase
`ifdef T03_LSU_MISALIGN_TRAP_EN
    req_mis  = req_legal && (((ls_funct3[1:0] == 2'b01) && ls_addr[0]) ||
                             ((ls_funct3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00)));
    req_trap = !req_legal || req_mis;
`else
    req_trap = !req_legal;
`endif
  end

  // Lane extraction and store merge; half lanes always have lo_q[0]=0 here
  logic [4:0]  shamt;
  logic [31:0] rd_sh, lane_mask, wd_sh, merged, extracted;

  always_comb begin
    shamt     = {lo_q, 3'b000};
    rd_sh     = data_read >> shamt;
    wd_sh     = wdata_q << shamt;
    case (f3_q[1:0])
      2'b00:   lane_mask = 32'h0000_00FF << shamt;
      2'b01:   lane_mask = 32'h0000_FFFF << shamt;
      default: lane_mask = '1;
    endcase
    merged = (data_read & ~lane_mask) | (wd_sh & lane_mask);
    case (f3_q)
      3'b000:  extracted = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  extracted = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  extracted = {24'h0, rd_sh[7:0]};
      3'b101:  extracted = {16'h0, rd_sh[15:0]};
      default: extracted = rd_sh;
    endcase
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt;
    we_n            = we_q;
    f3_n            = f3_q;
    lo_n            = lo_q;
    wdata_n         = wdata_q;
    mis_n           = mis_q;
    ls_rdata_n      = ls_rdata;
    data_address_n  = data_address;
    data_to_write_n = data_to_write;
    ls_busy_n       = ls_busy;
    ls_done_n       = 1'b0;
    ls_misaligned_n = 1'b0;
    dm_read_en_n    = 1'b0;
    dm_write_en_n   = 1'b0;

    case (state)
      S_IDLE: begin
        // ls_busy is still high in the cycle right after ls_done; requests there are dropped
        ls_busy_n = 1'b0;
        if (ls_req && !ls_busy) begin
          ls_busy_n      = 1'b1;
          we_n           = ls_we;
          f3_n           = ls_funct3;
          lo_n           = req_lo;
          wdata_n        = ls_wdata;
          mis_n          = req_mis;
          ls_rdata_n     = '0;
          data_address_n = {ls_addr[31:2], 2'b00};
          if (req_trap) begin
            state_n = S_FAULT;
          end else if (ls_we && (ls_funct3[1:0] == 2'b10)) begin
            state_n = S_WR;
          end else begin
            state_n = S_RD;
          end
        end
      end
      S_RD: begin
        dm_read_en_n = 1'b1;
        cnt_n        = '0;
        state_n      = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt == CNT_LAST) begin
          if (we_q) begin
            wdata_n = merged;
            state_n = S_WR;
          end else begin
            ls_rdata_n = extracted;
            state_n    = S_DONE;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_WR: begin
        dm_write_en_n   = 1'b1;
        data_to_write_n = wdata_q;
        state_n         = S_DONE;
      end
      // One idle cycle so a suppressed access completes with the same latency as SW
      S_FAULT: state_n = S_DONE;
      S_DONE: begin
        ls_done_n       = 1'b1;
        ls_misaligned_n = mis_q;
        state_n         = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      f3_q          <= '0;
      lo_q          <= '0;
      wdata_q       <= '0;
      mis_q         <= 1'b0;
      ls_rdata      <= '0;
      ls_done       <= 1'b0;
      ls_busy       <= 1'b0;
      ls_misaligned <= 1'b0;
      data_address  <= '0;
      dm_read_en    <= 1'b0;
      dm_write_en   <= 1'b0;
      data_to_write <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      we_q          <= we_n;
      f3_q          <= f3_n;
      lo_q          <= lo_n;
      wdata_q       <= wdata_n;
      mis_q         <= mis_n;
      ls_rdata      <= ls_rdata_n;
      ls_done       <= ls_done_n;
      ls_busy       <= ls_busy_n;
      ls_misaligned <= ls_misaligned_n;
      data_address  <= data_address_n;
      dm_read_en    <= dm_read_en_n;
      dm_write_en   <= dm_write_en_n;
      data_to_write <= data_to_write_n;
    end
  end

endmodule

// File: tb/tb_t03_load_store_unit.sv
// Directed bench for t03_load_store_unit: scoreboard of load results, latency and enable checks.
module tb_t03_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A (RD_WAIT_CYCLES=1)
  logic        ls_req, ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata, ls_rdata, data_address, data_to_write, data_read;
  logic        ls_done, ls_busy, ls_misaligned, dm_read_en, dm_write_en;

  // DUT B (RD_WAIT_CYCLES=3)
  logic        b_ls_req, b_ls_we;
  logic [2:0]  b_ls_funct3;
  logic [31:0] b_ls_addr, b_ls_wdata, b_ls_rdata, b_data_address, b_data_to_write, b_data_read;
  logic        b_ls_done, b_ls_busy, b_ls_misaligned, b_dm_read_en, b_dm_write_en;

  logic [31:0] mem [0:63];
  assign data_read   = mem[data_address[7:2]];
  assign b_data_read = mem[b_data_address[7:2]];
  always @(posedge clk) if (dm_write_en) mem[data_address[7:2]] <= data_to_write;

  t03_load_store_unit #(.RD_WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .ls_busy(ls_busy), .ls_misaligned(ls_misaligned), .data_address(data_address),
    .dm_read_en(dm_read_en), .dm_write_en(dm_write_en), .data_to_write(data_to_write),
    .data_read(data_read)
  );

  t03_load_store_unit #(.RD_WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_funct3(b_ls_funct3),
    .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata), .ls_rdata(b_ls_rdata), .ls_done(b_ls_done),
    .ls_busy(b_ls_busy), .ls_misaligned(b_ls_misaligned), .data_address(b_data_address),
    .dm_read_en(b_dm_read_en), .dm_write_en(b_dm_write_en), .data_to_write(b_data_to_write),
    .data_read(b_data_read)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read and write strobes must never overlap on either instance
  always @(negedge clk) begin
    chk("rd_wr_excl", {31'h0, dm_read_en & dm_write_en}, 32'h0);
    chk("b_rd_wr_excl", {31'h0, b_dm_read_en & b_dm_write_en}, 32'h0);
  end

  task automatic run_op(input string tag, input bit which, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_mis, input int exp_lat,
                        input int exp_rds, input int exp_wrs, input int exp_wr_edge,
                        input bit hold);
    int lat, rds, wrs, wr_edge;
    logic done_s, rd_s, wr_s, busy_s, mis_s;
    logic [31:0] rdata_s;
    exp_t e;
    e.rdata = exp_rd;
    e.mis   = exp_mis;
    sb_q.push_back(e);
    @(negedge clk);
    if (which) begin
      b_ls_req = 1'b1; b_ls_we = we; b_ls_funct3 = f3; b_ls_addr = addr; b_ls_wdata = wd;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wd;
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      ls_req = 1'b0; b_ls_req = 1'b0;
      ls_addr = 32'hFFFF_FFFF; ls_wdata = 32'h5A5A_5A5A; ls_funct3 = 3'b111;
    end
    lat = -1; rds = 0; wrs = 0; wr_edge = -1;
    rdata_s = '0; mis_s = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      done_s  = which ? b_ls_done : ls_done;
      rd_s    = which ? b_dm_read_en : dm_read_en;
      wr_s    = which ? b_dm_write_en : dm_write_en;
      rdata_s = which ? b_ls_rdata : ls_rdata;
      mis_s   = which ? b_ls_misaligned : ls_misaligned;
      if (rd_s) rds++;
      if (wr_s) begin
        wrs++;
        wr_edge = k;
      end
      if (done_s) begin
        lat = k;
        break;
      end
    end
    ls_req = 1'b0; b_ls_req = 1'b0;
    e = sb_q.pop_front();
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rdata_s, e.rdata);
    chk({tag, "_misaligned"}, {31'h0, mis_s}, {31'h0, e.mis});
    chk({tag, "_read_pulses"}, 32'(rds), 32'(exp_rds));
    chk({tag, "_write_pulses"}, 32'(wrs), 32'(exp_wrs));
    chk({tag, "_write_edge"}, 32'(wr_edge), 32'(exp_wr_edge));
    @(posedge clk);
    #1;
    busy_s = which ? b_ls_busy : ls_busy;
    chk({tag, "_busy_drop"}, {31'h0, busy_s}, 32'h0);
  endtask

  initial begin
    int wr_seen;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'h80FF_7F01;
    mem[5] = 32'h1122_3344;
    rst = 1'b1;
    ls_req = 1'b0; ls_we = 1'b0; ls_funct3 = '0; ls_addr = '0; ls_wdata = '0;
    b_ls_req = 1'b0; b_ls_we = 1'b0; b_ls_funct3 = '0; b_ls_addr = '0; b_ls_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {26'h0, ls_done, ls_busy, ls_misaligned, dm_read_en, dm_write_en, b_ls_busy},
        32'h0);
    chk("reset_rdata", ls_rdata, 32'h0);
    chk("reset_addr", data_address, 32'h0);
    chk("reset_wdata", data_to_write, 32'h0);

    //      tag     dut we  f3      addr          wdata         exp_rdata     mis lat rd wr wedge hold
    run_op("lb13",  0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FF80, 0, 3, 1, 0, -1, 0);
    run_op("lbu12", 0, 0, 3'b100, 32'h12, 32'h0, 32'h0000_00FF, 0, 3, 1, 0, -1, 0);
    run_op("lh10",  0, 0, 3'b001, 32'h10, 32'h0, 32'h0000_7F01, 0, 3, 1, 0, -1, 0);
    run_op("lhu12", 0, 0, 3'b101, 32'h12, 32'h0, 32'h0000_80FF, 0, 3, 1, 0, -1, 0);
    run_op("lw10",  0, 0, 3'b010, 32'h10, 32'h0, 32'h80FF_7F01, 0, 3, 1, 0, -1, 0);
`ifdef T03_LSU_MISALIGN_TRAP_EN
    run_op("lw11m", 0, 0, 3'b010, 32'h11, 32'h0, 32'h0, 1, 2, 0, 0, -1, 0);
    run_op("lh13m", 0, 0, 3'b001, 32'h13, 32'h0, 32'h0, 1, 2, 0, 0, -1, 0);
`else
    run_op("lw11m", 0, 0, 3'b010, 32'h11, 32'h0, 32'h80FF_7F01, 0, 3, 1, 0, -1, 0);
    run_op("lh13m", 0, 0, 3'b001, 32'h13, 32'h0, 32'hFFFF_80FF, 0, 3, 1, 0, -1, 0);
`endif
    run_op("lw_hold", 0, 0, 3'b010, 32'h10, 32'h0, 32'h80FF_7F01, 0, 3, 1, 0, -1, 1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_no_requeue", {30'h0, ls_busy, dm_read_en}, 32'h0);
    end
    run_op("b_lw10", 1, 0, 3'b010, 32'h10, 32'h0, 32'h80FF_7F01, 0, 5, 1, 0, -1, 0);

    run_op("ld_f3_011", 0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 0, 2, 0, 0, -1, 0);
    run_op("st_f3_100", 0, 1, 3'b100, 32'h10, 32'h1, 32'h0, 0, 2, 0, 0, -1, 0);
    chk("illegal_store_mem", mem[4], 32'h80FF_7F01);

    run_op("sh12", 0, 1, 3'b001, 32'h12, 32'hABCD_1234, 32'h0, 0, 4, 1, 1, 3, 0);
    chk("sh12_mem", mem[4], 32'h1234_7F01);
    run_op("sb11", 0, 1, 3'b000, 32'h11, 32'h0000_00AA, 32'h0, 0, 4, 1, 1, 3, 0);
    chk("sb11_mem", mem[4], 32'h1234_AA01);
    run_op("lb11", 0, 0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FFAA, 0, 3, 1, 0, -1, 0);
    run_op("sw20", 0, 1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 2, 0, 1, 1, 0);
    chk("sw20_mem", mem[8], 32'hDEAD_BEEF);

    // SB aborted by reset while waiting for read data
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b000; ls_addr = 32'h15; ls_wdata = 32'h55;
    @(posedge clk);
    #1 ls_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_abort_busy", {31'h0, ls_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wr_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dm_write_en || ls_done || ls_busy) wr_seen++;
    end
    chk("rst_abort_activity", 32'(wr_seen), 32'h0);
    chk("rst_abort_mem", mem[5], 32'h1122_3344);
    chk("b_never_wrote", b_data_to_write, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
